// File: rtl/prog_loader_pkg.sv
// Shared CPU package: loader state encoding, program memory geometry, fill value and opcodes.
package prog_loader_pkg;

  localparam int unsigned DEPTH_DEF     = 256;
  localparam int unsigned ADDR_W        = 8;
  localparam logic [7:0]  FILL_WORD_DEF = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StRun
  } ld_state_e;

  // Core opcode space (upper nibble of the instruction byte).
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program memory: one synchronous write port, one registered read port, no reset on the array.
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: clears program memory, streams a host program in, then serves core fetches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]  FILL_WORD = FILL_WORD_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic       load_start,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] input_ins,
  output logic       core_hold,
  output logic       load_done,
  output logic [7:0] load_count,
  output logic       err_overflow
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [7:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rvalid_q, rvalid_d;

  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ram_we    = 1'b0;
    ram_wdata = FILL_WORD;
    case (state_q)
      StIdle, StRun: begin
        if (load_start) begin
          state_d = StClear;
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StClear: begin
        ram_we = 1'b1;
        if (wptr_q == LastAddr) begin
          state_d = StLoad;
          wptr_d  = '0;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      StLoad: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_wdata = load_data;
          count_d   = sat_inc8(count_q);
          // The pointer parks on the last address instead of wrapping.
          if (wptr_q != LastAddr) begin
            wptr_d = wptr_q + 1'b1;
          end
          if (load_last) begin
            state_d = StRun;
          end else if (wptr_q == LastAddr) begin
            state_d = StRun;
            ovf_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Fetch data is only trusted once a read was issued while staying in RUN.
    rvalid_d = (state_q == StRun) && (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
    end
  end

  prog_ram #(
    .DEPTH(DEPTH)
  ) u_prog_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(wptr_q),
    .wdata_i(ram_wdata),
    .re_i   (state_q == StRun),
    .raddr_i(pc),
    .rdata_o(ram_rdata)
  );

  assign load_ready   = (state_q == StLoad);
  assign core_hold    = (state_q != StRun);
  assign load_done    = (state_q == StRun);
  assign load_count   = count_q;
  assign err_overflow = ovf_q;
  assign input_ins    = rvalid_q ? ram_rdata : FILL_WORD;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: FILL_WORD, default 8'h00, value written to every unloaded location and driven on input_ins outside RUN.
REQ-002 Parameter: DEPTH, default 256, program memory depth in bytes (addressed by 8-bit pc).
REQ-003 Port: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port: CLB  in  1  reset, synchronous, active-high.
REQ-005 Port: load_start  in  1  one-cycle pulse requesting a new program load.
REQ-006 Port: load_data  in  8  program byte offered by host.
REQ-007 Port: load_valid  in  1  load_data valid this cycle.
REQ-008 Port: load_last  in  1  qualifies load_data as final byte of the program.
REQ-009 Port: load_ready  out  1  loader accepts load_data this cycle.
REQ-010 Port: pc  in  8  instruction address from the core.
REQ-011 Port: input_ins  out  8  registered instruction byte delivered to the core IR.
REQ-012 Port: core_hold  out  1  1 = core must be held cleared.
REQ-013 Port: load_done  out  1  1 = valid program resident, serving fetches.
REQ-014 Port: load_count  out  8  number of bytes accepted in the current/last load, saturating at 255.
REQ-015 Port: err_overflow  out  1  sticky: a load ran past the last address without load_last.

Function
REQ-016 FSM states IDLE, CLEAR, LOAD, RUN; exactly one active.
REQ-017 IDLE: load_start -> CLEAR; otherwise hold.
REQ-018 CLEAR: write FILL_WORD to one address per cycle, 0 upward; after address DEPTH-1 written (DEPTH cycles) -> LOAD with write pointer 0.
REQ-019 LOAD: load_ready=1; byte accepted iff load_valid & load_ready; accepted byte written to mem[wptr], wptr and load_count increment.
REQ-020 LOAD: accepted byte with load_last=1 -> RUN next cycle; that byte is written.
REQ-021 LOAD: byte accepted at wptr=DEPTH-1 with load_last=0 -> byte written, err_overflow set, -> RUN; wptr does not wrap.
REQ-022 RUN: input_ins = mem[pc] registered, one-cycle latency; pc change at edge N visible on input_ins after edge N+1.
REQ-023 Outside RUN, input_ins = FILL_WORD; load_ready=0 outside LOAD.
REQ-024 core_hold=1 in every state except RUN; load_done=1 only in RUN.
REQ-025 RUN: load_start -> CLEAR; core_hold reasserts in the cycle after the pulse; load_count and err_overflow clear on entry to CLEAR.
REQ-026 load_start in CLEAR or LOAD ignored; load_valid outside LOAD ignored (no write).
REQ-027 Write and read of the same address in one cycle cannot occur (writes only outside RUN, reads only in RUN).

Reset
REQ-028 CLB=1 at an edge: state IDLE, wptr 0, load_count 0, err_overflow 0, input_ins FILL_WORD, core_hold 1, load_done 0, load_ready 0.
REQ-029 Reset mid-CLEAR or mid-LOAD aborts; memory contents undefined until the next CLEAR; CLB dominates load_start.
REQ-030 Memory array itself is not reset.

Structure
REQ-031 State encoding, FILL_WORD default and DEPTH in the shared CPU package alongside opcode constants.
REQ-032 One sub-module: prog_ram (DEPTH x 8, one synchronous write port, one registered read port).

Verification
REQ-033 Reset, then load_start, 256 idle cycles -> load_ready rises exactly on cycle 257; core_hold=1 throughout.
REQ-034 Load bytes 8'h1A,8'h2B,8'h3C (last on 3C) with load_valid gaps -> load_count=3, load_done=1; pc=1 -> input_ins=8'h2B one cycle later; pc=5 -> 8'h00.
REQ-035 Load 256 bytes without load_last -> err_overflow=1, load_count=255 (saturated), RUN entered, mem[255] holds last byte.
REQ-036 In RUN pulse load_start, reload single byte 8'hF0 with last -> pc=0 gives 8'hF0, pc=1 gives FILL_WORD, err_overflow cleared.
REQ-037 CLB asserted mid-LOAD after 2 bytes -> next cycle state IDLE, load_ready=0, core_hold=1, load_count=0.
REQ-038 load_start pulsed during CLEAR and LOAD -> no restart; CLEAR duration stays 256 cycles.
